corner_gather: RTL
==================

# corner_gather

Downstream consumer of the corner index lookup stage. On `start` it snapshots the 144-bit cube state and sequences `corner_num` 0..23 into the lookup stage. From each returned `ind` it computes a sticker bit position and extracts the 3-bit colour at that position. It then packs the 24 colours into a 72-bit corner vector for the solver, signalling completion with a one-cycle `done` pulse.

## Interface
Parameters: none. All widths are fixed by the cube encoding.
- `clock` in 1: single clock. All logic is on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request a gather. Sampled only in IDLE.
- `cubestate` in 144: packed sticker colours, 3 bits each. Sampled only on the accepting edge.
- `ind` in 8: offset from the lookup stage. It is registered there, so it is valid 1 cycle after `corner_num`.
- `corner_num` out 5: corner index driven to the lookup stage. Reset value 0.
- `busy` out 1: high from the accept edge until the done edge. Reset value 0.
- `done` out 1: one-cycle pulse when `corners` is updated. Reset value 0.
- `corners` out 72: packed result. Colour of corner n sits at [3(23-n)+2 : 3(23-n)]. Reset value 0.
- `range_err` out 1: sticky out-of-range flag, cleared on accept. Reset value 0. Exists only under the macro described in Configuration.

## Operation
- States are IDLE, SCAN, DRAIN, DONE. Reset forces IDLE and clears all registers.
- IDLE, with `start`=1:
  - Latch `cubestate` into `snap`.
  - Set `corner_num`<=0.
  - Set `busy`<=1.
  - Clear the working vector `work`.
  - Clear `range_err`.
  - Go to SCAN.
- SCAN:
  - Each edge, `corner_num` increments.
  - The tag register `cap_num` is `corner_num` delayed by 1 edge, and `cap_vld` is the matching valid bit.
  - At the edge where `corner_num`=23, hold `corner_num` and go to DRAIN.
- Capture, on every edge where `cap_vld`=1:
  - Compute `sel` = `ind` + 3*(23-`cap_num`), 9-bit unsigned with no truncation.
  - Write `snap[sel+2:sel]` into `work` at field `cap_num`.
- DRAIN: wait for the capture of n=23, then go to DONE.
- DONE: copy `work` into `corners`. Drive `done`=1 and `busy`=0 for exactly this cycle. Return to IDLE.
- `corners` holds its previous value throughout a gather. It changes only at done.
- `start` while busy is ignored and is not queued. `start` held high is re-accepted on the first IDLE cycle.
- Changes to `cubestate` during a gather have no effect, because all extraction reads `snap`.
- `reset_n` low mid-gather aborts immediately:
  - All outputs return to their reset values.
  - No `done` pulse is produced.
- Out-of-range extraction: if `sel` > 141, the extracted field is 3'b000.

## Timing
- Let E0 be the accepting edge.
- The capture of corner n occurs at edge E(n+2), so the last capture is at E25.
- `done`=1 and the new `corners` value are visible in the cycle after E26. The last DONE-state edge is E26.
- `busy` is high from after E0 through the cycle ending at E26.
- Minimum spacing between accepts is 27 edges (next accept at E27).
- `corner_num` is stable for a full cycle before each lookup edge. The lookup's own 1-cycle latency is absorbed by `cap_num`.

## Configuration
- Macro: `CORNER_GATHER_RANGE_CHECK_EN`.
- Defined:
  - `range_err` is a port.
  - It sets sticky on any capture with `sel` > 141 and clears on the next accept.
  - The field is still written as 3'b000.
- Undefined:
  - The `range_err` port is absent.
  - No comparison logic is generated.
  - Out-of-range fields read 3'b000.

## Test plan
- Uniform state: `cubestate` has every 3-bit field = 3'b101; pulse `start` -> `done` after E26 and `corners` = all 3'b101 fields (72'o555…5, 24 digits).
- Single sticker: `cubestate`=0 except [107:105]=3'b011 -> `corners` has 3'b011 at [71:69], [59:57], [35:33] and [11:9]; every other field is 0.
- Snapshot and ignore: change `cubestate` and pulse `start` at E5 of a gather -> the result reflects the E0 snapshot, and exactly one `done` pulse occurs.
- Reset mid-op: `reset_n`=0 at E12 -> `busy`=0, `corner_num`=0, `corners`=0, no `done`. A new `start` completes normally 27 edges after its accept.
- Range check (macro defined): force `ind`=8'd200 for `cap_num`=3 -> `range_err`=1 and `corners`[62:60]=0. The flag clears on the next accept.
- Back-to-back: hold `start`=1 -> accepts occur at E0 and E27, with `done` pulses after E26 and E53.

Source files
------------

// File: rtl/corner_gather.sv
// corner_gather: snapshots a 144-bit cube state and walks corner_num 0..23
// through the external corner index lookup. Each returned ind selects a
// 3-bit sticker colour, and the 24 colours are packed into a 72-bit corner
// vector that is published with a one-cycle done pulse.
// Optional feature macro: CORNER_GATHER_RANGE_CHECK_EN adds the sticky
// range_err output, which is set when a selected sticker lies past the
// end of the cube state.
module corner_gather (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [143:0] cubestate,
    input  logic [7:0]   ind,
    output logic [4:0]   corner_num,
    output logic         busy,
    output logic         done,
    output logic [71:0]  corners
`ifdef CORNER_GATHER_RANGE_CHECK_EN
    ,
    output logic         range_err
`endif
);

    localparam int unsigned NUM_CORNERS = 24;
    localparam int unsigned FIELD_W     = 3;
    localparam int unsigned SNAP_W      = 144;
    localparam int unsigned CORNERS_W   = 72;
    localparam int unsigned NUM_W       = 5;
    localparam int unsigned POS_W       = 7;
    localparam int unsigned SEL_W       = 9;
    localparam int unsigned MAX_SEL     = SNAP_W - FIELD_W;
    localparam logic [NUM_W-1:0] LAST_CORNER = NUM_W'(NUM_CORNERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   accept_c;
    logic [SNAP_W-1:0]      snap;
    logic [CORNERS_W-1:0]   work;
    logic [NUM_W-1:0]       cap_num;
    logic                   cap_vld;
    logic [POS_W-1:0]       fpos_c;
    logic [SEL_W-1:0]       sel_c;
    logic                   in_range_c;
    logic [FIELD_W-1:0]     field_c;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; accept_c marks the edge that takes a new request
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SCAN;
                    accept_c = 1'b1;
                end
            end
            SCAN: begin
                if (corner_num == LAST_CORNER) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cap_vld && (cap_num == LAST_CORNER)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticker selection for the corner being captured this cycle
    always_comb begin
        fpos_c     = POS_W'(FIELD_W * (NUM_CORNERS - 1 - 32'(cap_num)));
        sel_c      = SEL_W'(ind) + SEL_W'(fpos_c);
        in_range_c = (sel_c <= SEL_W'(MAX_SEL));
        field_c    = '0;
        if (in_range_c) begin
            field_c = FIELD_W'(snap >> sel_c);
        end
    end

    // Datapath: snapshot, corner sequencing, capture and result publication
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            snap       <= '0;
            work       <= '0;
            corners    <= '0;
            corner_num <= '0;
            cap_num    <= '0;
            cap_vld    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CORNER_GATHER_RANGE_CHECK_EN
            range_err  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                snap       <= cubestate;
                corner_num <= '0;
                busy       <= 1'b1;
                work       <= '0;
                cap_vld    <= 1'b0;
`ifdef CORNER_GATHER_RANGE_CHECK_EN
                range_err  <= 1'b0;
`endif
            end else begin
                // cap_num trails corner_num by one edge to match the lookup latency
                if (state_q == SCAN) begin
                    cap_num <= corner_num;
                    cap_vld <= 1'b1;
                    if (corner_num != LAST_CORNER) begin
                        corner_num <= corner_num + NUM_W'(1);
                    end
                end else begin
                    cap_vld <= 1'b0;
                end
                if (cap_vld) begin
                    work[fpos_c +: FIELD_W] <= field_c;
`ifdef CORNER_GATHER_RANGE_CHECK_EN
                    if (!in_range_c) begin
                        range_err <= 1'b1;
                    end
`endif
                end
                if (state_q == DONE) begin
                    corners <= work;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
            end
        end
    end

endmodule
